sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the next generation of the team's sync FIFO.
- Arbitrary depth (not limited to powers of two); true DEPTH-entry capacity.
- Adds almost-full/almost-empty thresholds, an occupancy level output, sticky overflow/underflow error flags, a synchronous flush, and a first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer blocks in the same clock domain, for rate smoothing and back-pressure.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 7, number of storage entries (>=2, any integer)
AF_LEVEL, DEPTH-1, almost_full asserts when level >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when level <= AE_LEVEL
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents and error flags
wr_en  in  1  write request
wr_data  in  WIDTH  write data
rd_en  in  1  read request (standard mode) / pop acknowledge (FWFT mode)
rd_data  out  WIDTH  read data
rd_valid  out  1  rd_data holds valid data
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_LEVEL
almost_empty  out  1  level <= AE_LEVEL
level  out  CW  current occupancy, CW = clog2(DEPTH+1)
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=0, async) clears wr_ptr, rd_ptr, level, overflow, underflow, rd_valid and rd_data to 0. Storage array is not reset.
- Flags are combinational from registered level: empty=1, full=0, almost_empty=1 out of reset.
- Write accept: wr_acc = wr_en & !full. Read accept: rd_acc = rd_en & !empty. Both use the flags at the start of the cycle.
- Write when full is dropped: data discarded, state unchanged, overflow set. This holds even if a read is accepted in the same cycle.
- Read when empty: underflow set, pointers unchanged, rd_valid=0 next cycle.
- Pointers: 0..DEPTH-1, wrap to 0 after DEPTH-1, independent of power-of-two.
- Level update: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither. Level never exceeds DEPTH and never goes below 0.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 on the next edge.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en pops the head entry at the next edge.
  - A word written into an empty FIFO appears on rd_data the cycle after its write edge.
- flush=1:
  - At the next edge, wr_ptr=rd_ptr=level=0, rd_valid=0, overflow=underflow=0.
  - Overrides wr_en/rd_en in the same cycle; neither is accepted and neither error flag is set.
- Mid-operation reset: immediate clear of all state per the reset list above. No partial write is committed.
- Thresholds must satisfy 0 <= AE_LEVEL < AF_LEVEL <= DEPTH; elaboration error otherwise.

Decomposition:
- Package sync_fifo_pkg holds:
  - function clog2
  - localparam for pointer width PW = clog2(DEPTH)
  - localparam for level width CW = clog2(DEPTH+1)
  - pointer-increment-with-wrap function
- One sub-module, fifo_regfile: DEPTH x WIDTH storage with 1 synchronous write port and 1 asynchronous read port.
- Control (pointers, level, flags, errors, read register) stays in sync_fifo_param.

Test Plan:
- Reset then fill (FWFT=0, DEPTH=7): write 0x10..0x16 on 7 consecutive cycles.
  -> full=1 after the 7th edge, level=7, almost_full=1 from level 6; 8th write 0xFF -> overflow=1, level stays 7.
- Drain after fill: rd_en on 7 cycles.
  -> rd_data 0x10..0x16, each with rd_valid=1 one cycle after its rd_en; empty=1 at end; 8th rd_en -> underflow=1, rd_valid=0.
- Wrap-around with simultaneous access: hold level=3, assert wr_en and rd_en for 20 cycles.
  -> level constant at 3, data ordering preserved across pointer wrap at index 6.
- FWFT=1: write 0xA5 into an empty FIFO.
  -> rd_valid=1 and rd_data=0xA5 the next cycle with no rd_en; rd_en for one cycle -> empty=1, rd_valid=0.
- Flush at level=5 with wr_en=1 and rd_en=1 and overflow=1.
  -> next cycle level=0, empty=1, overflow=0, rd_valid=0, the written word is not stored.
- Assert rst=0 asynchronously mid-burst at level=4.
  -> all outputs reach reset values before the next clk edge; after release, the first write/read returns the new data only.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared helpers for the parametrised sync FIFO: ceiling log2 for sizing
// pointer/level fields and a modulo-DEPTH pointer increment that works for
// any depth, not just powers of two.
package sync_fifo_pkg;

   // Smallest legal depth; a one-entry FIFO makes almost-full/empty meaningless.
   localparam int unsigned MIN_DEPTH = 2;

   // Ceiling log2, clamped to at least 1 so a field is never zero bits wide.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      longint unsigned v;
      r = 0;
      v = 1;
      while (v < longint'(n)) begin
         v = v << 1;
         r = r + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   // Advance a pointer, wrapping to 0 after depth-1.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_param_regfile.sv
// fifo_regfile
// DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
//   i_clk      clock
//   i_wr_en    write strobe (already qualified by the controller)
//   i_wr_addr  write index, 0..DEPTH-1
//   i_wr_data  write data
//   i_rd_addr  read index, 0..DEPTH-1
//   o_rd_data  combinational read data
module fifo_regfile #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 7,
   parameter int unsigned AW    = 3
) (
   input  logic             i_clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock FIFO with arbitrary depth, almost-full/almost-empty thresholds,
// occupancy level, sticky overflow/underflow flags, synchronous flush and an
// optional first-word-fall-through read mode.
//   i_clk           rising-edge clock
//   i_rst_n         asynchronous active-low reset
//   i_flush         synchronous clear of contents and error flags
//   i_wr_en         write request
//   i_wr_data       write data
//   i_rd_en         read request (FWFT=0) / pop acknowledge (FWFT=1)
//   o_rd_data       read data
//   o_rd_valid      o_rd_data holds valid data
//   o_full          level == DEPTH
//   o_empty         level == 0
//   o_almost_full   level >= AF_LEVEL
//   o_almost_empty  level <= AE_LEVEL
//   o_level         current occupancy
//   o_overflow      sticky: write attempted while full
//   o_underflow     sticky: read attempted while empty
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 7,
   parameter int unsigned AF_LEVEL = DEPTH - 1,
   parameter int unsigned AE_LEVEL = 1,
   parameter int unsigned FWFT     = 0
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_flush,
   input  logic                         i_wr_en,
   input  logic [WIDTH-1:0]             i_wr_data,
   input  logic                         i_rd_en,
   output logic [WIDTH-1:0]             o_rd_data,
   output logic                         o_rd_valid,
   output logic                         o_full,
   output logic                         o_empty,
   output logic                         o_almost_full,
   output logic                         o_almost_empty,
   output logic [clog2(DEPTH + 1)-1:0]  o_level,
   output logic                         o_overflow,
   output logic                         o_underflow
);

   localparam int unsigned PW = clog2(DEPTH);
   localparam int unsigned CW = clog2(DEPTH + 1);

   if (!(WIDTH >= 1 && DEPTH >= MIN_DEPTH && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH))
   begin : gen_bad_params
      $error("sync_fifo_param: need WIDTH>=1, DEPTH>=2, AE_LEVEL < AF_LEVEL <= DEPTH");
   end

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_level;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_full;
   logic             w_empty;
   logic             w_wr_acc;
   logic             w_rd_acc;
   logic [WIDTH-1:0] w_mem_rdata;

   // Flags come from the registered level, so accept decisions use the
   // start-of-cycle state. Flush suppresses both accepts.
   assign w_full   = (r_level == CW'(DEPTH));
   assign w_empty  = (r_level == '0);
   assign w_wr_acc = i_wr_en & ~w_full & ~i_flush;
   assign w_rd_acc = i_rd_en & ~w_empty & ~i_flush;

   fifo_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_regfile (
      .i_clk     (i_clk),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (i_wr_data),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_mem_rdata)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (i_flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= PW'(ptr_inc(32'(r_wr_ptr), DEPTH));
         end
         if (w_rd_acc) begin
            r_rd_ptr <= PW'(ptr_inc(32'(r_rd_ptr), DEPTH));
         end
         unique case ({w_wr_acc, w_rd_acc})
            2'b10:   r_level <= r_level + CW'(1);
            2'b01:   r_level <= r_level - CW'(1);
            default: r_level <= r_level;
         endcase
         // A write while full is dropped even if a read frees a slot this cycle.
         if (i_wr_en && w_full) begin
            r_overflow <= 1'b1;
         end
         if (i_rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   if (FWFT == 0) begin : gen_std
      logic [WIDTH-1:0] r_rd_data;
      logic             r_rd_valid;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
         end else if (i_flush) begin
            r_rd_valid <= 1'b0;
         end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
               r_rd_data <= w_mem_rdata;
            end
         end
      end

      assign o_rd_data  = r_rd_data;
      assign o_rd_valid = r_rd_valid;
   end else begin : gen_fwft
      // Head entry is always presented; rd_en acts as a pop.
      assign o_rd_data  = w_mem_rdata;
      assign o_rd_valid = ~w_empty;
   end

   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = (r_level >= CW'(AF_LEVEL));
   assign o_almost_empty = (r_level <= CW'(AE_LEVEL));
   assign o_level        = r_level;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule
